// File: rtl/calc_ctrl_pkg.sv
// Shared definitions for the calculator controller: ALU opcodes, op_sel decode,
// FSM state type and undo-stack sizing.
package calc_ctrl_pkg;

   localparam logic [3:0] ALUOP_AND               = 4'b0000;
   localparam logic [3:0] ALUOP_OR                = 4'b0001;
   localparam logic [3:0] ALUOP_ADD               = 4'b0010;
   localparam logic [3:0] ALUOP_SUB               = 4'b0110;
   localparam logic [3:0] ALUOP_LESS_THAN         = 4'b0111;
   localparam logic [3:0] ALUOP_SHIFT_RIGHT_LOGIC = 4'b1000;
   localparam logic [3:0] ALUOP_SHIFT_LEFT        = 4'b1001;
   localparam logic [3:0] ALUOP_SHIFT_RIGHT_ARITH = 4'b1010;
   localparam logic [3:0] ALUOP_XOR               = 4'b1101;

   localparam int UNDO_ENTRIES = 4;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_EXEC = 1'b1
   } calc_state_e;

   function automatic logic [3:0] map_op(input logic [2:0] sel);
      logic [3:0] op;
      case (sel)
         3'd0:    op = ALUOP_ADD;
         3'd1:    op = ALUOP_SUB;
         3'd2:    op = ALUOP_AND;
         3'd3:    op = ALUOP_OR;
         3'd4:    op = ALUOP_XOR;
         3'd5:    op = ALUOP_LESS_THAN;
         3'd6:    op = ALUOP_SHIFT_LEFT;
         default: op = ALUOP_SHIFT_RIGHT_ARITH;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/calc_ctrl_if.sv
// Operand/result bundle between the calculator controller (master) and the
// purely combinational ALU (slave).
interface calc_ctrl_if;
   logic [31:0] alu_op1;
   logic [31:0] alu_op2;
   logic [3:0]  alu_op;
   logic [31:0] alu_result;
   logic        alu_zero;

   modport master (
      output alu_op1,
      output alu_op2,
      output alu_op,
      input  alu_result,
      input  alu_zero
   );

   modport slave (
      input  alu_op1,
      input  alu_op2,
      input  alu_op,
      output alu_result,
      output alu_zero
   );
endinterface

// File: rtl/calc_ctrl_btn_sync_edge.sv
// Two-flop synchronizer for a raw button plus a registered rising-edge one-shot.
// A held button yields a single one-cycle pulse.
module btn_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic btn_in,
   output logic pulse
);

   logic sync1_q, sync1_d;
   logic sync2_q, sync2_d;
   logic sync3_q, sync3_d;
   logic pulse_q, pulse_d;

   always_comb begin
      sync1_d = btn_in;
      sync2_d = sync1_q;
      sync3_d = sync2_q;
      pulse_d = sync2_q & ~sync3_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         sync3_q <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         sync3_q <= sync3_d;
         pulse_q <= pulse_d;
      end
   end

   assign pulse = pulse_q;

endmodule

// File: rtl/calc_ctrl.sv
// Calculator controller: accumulator, operand capture, ALU drive and writeback.
// Optional undo stack (btnr, undo_depth) is built when CALC_UNDO_EN is defined.
module calc_ctrl
   import calc_ctrl_pkg::*;
#(
   parameter int OP_W  = 16,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             btnc,
   input  logic             btnl,
`ifdef CALC_UNDO_EN
   input  logic             btnr,
   output logic [2:0]       undo_depth,
`endif
   input  logic [OP_W-1:0]  sw,
   input  logic [2:0]       op_sel,
   calc_ctrl_if.master      alu,
   output logic [31:0]      acc,
   output logic             zero_flag,
   output logic             busy,
   output logic [CNT_W-1:0] op_count
);

`ifdef CALC_UNDO_EN
   localparam int NBTN = 3;
`else
   localparam int NBTN = 2;
`endif

   logic [NBTN-1:0] btn_raw;
   logic [NBTN-1:0] btn_pulse;

`ifdef CALC_UNDO_EN
   assign btn_raw = {btnr, btnl, btnc};
`else
   assign btn_raw = {btnl, btnc};
`endif

   for (genvar gi = 0; gi < NBTN; gi++) begin : g_btn
      btn_sync_edge u_sync (
         .clk    (clk),
         .rst    (rst),
         .btn_in (btn_raw[gi]),
         .pulse  (btn_pulse[gi])
      );
   end

   logic exe_pulse;
   logic clr_pulse;
   assign exe_pulse = btn_pulse[0];
   assign clr_pulse = btn_pulse[1];

   calc_state_e      state_q, state_d;
   logic [31:0]      acc_q, acc_d;
   logic [31:0]      op2_q, op2_d;
   logic [3:0]       aluop_q, aluop_d;
   logic             zero_q, zero_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [31:0] sw_ext;
   assign sw_ext = {{(32-OP_W){sw[OP_W-1]}}, sw};

   logic        undo_avail;
   logic [31:0] undo_top;

`ifdef CALC_UNDO_EN
   logic        push;
   logic        pop;
   logic [31:0] stack_q [UNDO_ENTRIES];
   logic [31:0] stack_d [UNDO_ENTRIES];
   logic [2:0]  depth_q, depth_d;

   assign undo_avail = btn_pulse[2] && (depth_q != 3'd0);
   assign undo_top   = stack_q[0];

   // Entry 0 is the most recent value; a push into a full stack drops the last entry.
   always_comb begin
      stack_d = stack_q;
      depth_d = depth_q;
      if (push) begin
         stack_d[0] = acc_q;
         for (int i = 1; i < UNDO_ENTRIES; i++) begin
            stack_d[i] = stack_q[i-1];
         end
         if (depth_q != 3'(UNDO_ENTRIES)) begin
            depth_d = depth_q + 3'd1;
         end
      end else if (pop) begin
         for (int i = 0; i < UNDO_ENTRIES - 1; i++) begin
            stack_d[i] = stack_q[i+1];
         end
         stack_d[UNDO_ENTRIES-1] = '0;
         depth_d = depth_q - 3'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < UNDO_ENTRIES; i++) begin
            stack_q[i] <= '0;
         end
         depth_q <= 3'd0;
      end else begin
         stack_q <= stack_d;
         depth_q <= depth_d;
      end
   end

   assign undo_depth = depth_q;
`else
   assign undo_avail = 1'b0;
   assign undo_top   = '0;
`endif

   // Priority in IDLE: clear, then undo, then execute; pulses in EXEC are dropped.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      op2_d   = op2_q;
      aluop_d = aluop_q;
      zero_d  = zero_q;
      cnt_d   = cnt_q;
`ifdef CALC_UNDO_EN
      push    = 1'b0;
      pop     = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (clr_pulse) begin
               acc_d  = '0;
               zero_d = 1'b1;
`ifdef CALC_UNDO_EN
               push   = 1'b1;
`endif
            end else if (undo_avail) begin
               acc_d = undo_top;
`ifdef CALC_UNDO_EN
               pop   = 1'b1;
`endif
            end else if (exe_pulse) begin
               op2_d   = sw_ext;
               aluop_d = map_op(op_sel);
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            acc_d   = alu.alu_result;
            zero_d  = alu.alu_zero;
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = ST_IDLE;
`ifdef CALC_UNDO_EN
            push    = 1'b1;
`endif
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         acc_q   <= '0;
         op2_q   <= '0;
         aluop_q <= ALUOP_ADD;
         zero_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         op2_q   <= op2_d;
         aluop_q <= aluop_d;
         zero_q  <= zero_d;
         cnt_q   <= cnt_d;
      end
   end

   assign alu.alu_op1 = acc_q;
   assign alu.alu_op2 = op2_q;
   assign alu.alu_op  = aluop_q;
   assign acc         = acc_q;
   assign zero_flag   = zero_q;
   assign busy        = (state_q == ST_EXEC);
   assign op_count    = cnt_q;

endmodule

// File: tb/tb_calc_ctrl.sv
// Directed bench for calc_ctrl with a behavioural ALU; build with CALC_UNDO_EN
// defined to also exercise the undo stack.
module tb_calc_ctrl;
   import calc_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        btnc = 1'b0;
   logic        btnl = 1'b0;
   logic        btnr = 1'b0;
   logic [15:0] sw = '0;
   logic [2:0]  op_sel = '0;
   logic [31:0] acc;
   logic        zero_flag;
   logic        busy;
   logic [7:0]  op_count;
`ifdef CALC_UNDO_EN
   logic [2:0]  undo_depth;
`endif

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] model_acc = '0;
   logic [7:0]  model_cnt = '0;

   calc_ctrl_if aif ();

   always #5 clk = ~clk;

   logic [31:0] alu_r;
   always_comb begin
      case (aif.alu_op)
         ALUOP_ADD:               alu_r = aif.alu_op1 + aif.alu_op2;
         ALUOP_SUB:               alu_r = aif.alu_op1 - aif.alu_op2;
         ALUOP_AND:               alu_r = aif.alu_op1 & aif.alu_op2;
         ALUOP_OR:                alu_r = aif.alu_op1 | aif.alu_op2;
         ALUOP_XOR:               alu_r = aif.alu_op1 ^ aif.alu_op2;
         ALUOP_LESS_THAN:         alu_r = {31'b0, $signed(aif.alu_op1) < $signed(aif.alu_op2)};
         ALUOP_SHIFT_LEFT:        alu_r = aif.alu_op1 << aif.alu_op2[4:0];
         ALUOP_SHIFT_RIGHT_ARITH: alu_r = $signed(aif.alu_op1) >>> aif.alu_op2[4:0];
         default:                 alu_r = '0;
      endcase
   end
   assign aif.alu_result = alu_r;
   assign aif.alu_zero   = (alu_r == 32'd0);

   calc_ctrl #(.OP_W(16), .CNT_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .btnc       (btnc),
      .btnl       (btnl),
`ifdef CALC_UNDO_EN
      .btnr       (btnr),
      .undo_depth (undo_depth),
`endif
      .sw         (sw),
      .op_sel     (op_sel),
      .alu        (aif),
      .acc        (acc),
      .zero_flag  (zero_flag),
      .busy       (busy),
      .op_count   (op_count)
   );

   typedef struct {
      logic [15:0] sw;
      logic [2:0]  sel;
      logic [3:0]  op;
      logic [31:0] acc;
      logic        zero;
   } vec_t;

   vec_t vecs [17];

   function automatic vec_t mk(input logic [15:0] s, input logic [2:0] sel,
                               input logic [3:0] op, input logic [31:0] a, input logic z);
      vec_t v;
      v.sw = s; v.sel = sel; v.op = op; v.acc = a; v.zero = z;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end else begin
         $display("ok   %s: 0x%08h", name, act);
      end
   endtask

   // Entered and left at posedge+1; checks the k+3 / k+4 latency of one execute.
   task automatic exec_op(input string tag, input vec_t v);
      logic [31:0] op2_exp;
      op2_exp = {{16{v.sw[15]}}, v.sw};
      sw = v.sw;
      op_sel = v.sel;
      btnc = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check({tag, " busy@k+2"}, 32'(busy), 32'd0);
      @(posedge clk);
      #1;
      check({tag, " busy@k+3"}, 32'(busy), 32'd1);
      check({tag, " alu_op2"}, aif.alu_op2, op2_exp);
      check({tag, " alu_op"}, 32'(aif.alu_op), 32'(v.op));
      check({tag, " alu_op1"}, aif.alu_op1, model_acc);
      @(posedge clk);
      #1;
      model_acc = v.acc;
      model_cnt = model_cnt + 8'd1;
      check({tag, " busy@k+4"}, 32'(busy), 32'd0);
      check({tag, " acc"}, acc, model_acc);
      check({tag, " zero"}, 32'(zero_flag), 32'(v.zero));
      check({tag, " op_count"}, 32'(op_count), 32'(model_cnt));
      btnc = 1'b0;
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic press(input logic c, input logic l, input logic r, input int hold,
                        output int busy_cycles);
      busy_cycles = 0;
      btnc = c; btnl = l; btnr = r;
      repeat (hold) begin
         @(posedge clk);
         #1;
         if (busy) busy_cycles++;
      end
      btnc = 1'b0; btnl = 1'b0; btnr = 1'b0;
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      btnc = 1'b0; btnl = 1'b0; btnr = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      model_acc = '0;
      model_cnt = '0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      int bc;
      vecs[0]  = mk(16'h0005, 3'd1 - 3'd1, ALUOP_ADD, 32'h0000_0005, 1'b0);
      vecs[1]  = mk(16'hFFFD, 3'd1, ALUOP_SUB,               32'h0000_0008, 1'b0);
      vecs[2]  = mk(16'h000C, 3'd2, ALUOP_AND,               32'h0000_0008, 1'b0);
      vecs[3]  = mk(16'h0003, 3'd3, ALUOP_OR,                32'h0000_000B, 1'b0);
      vecs[4]  = mk(16'h000F, 3'd4, ALUOP_XOR,               32'h0000_0004, 1'b0);
      vecs[5]  = mk(16'h0004, 3'd1, ALUOP_SUB,               32'h0000_0000, 1'b1);
      vecs[6]  = mk(16'hFFFF, 3'd5, ALUOP_LESS_THAN,         32'h0000_0000, 1'b1);
      vecs[7]  = mk(16'h0001, 3'd0, ALUOP_ADD,               32'h0000_0001, 1'b0);
      vecs[8]  = mk(16'h001F, 3'd6, ALUOP_SHIFT_LEFT,        32'h8000_0000, 1'b0);
      vecs[9]  = mk(16'h0004, 3'd7, ALUOP_SHIFT_RIGHT_ARITH, 32'hF800_0000, 1'b0);
      vecs[10] = mk(16'h0004, 3'd6, ALUOP_SHIFT_LEFT,        32'h8000_0000, 1'b0);
      vecs[11] = mk(16'h0001, 3'd5, ALUOP_LESS_THAN,         32'h0000_0001, 1'b0);
      vecs[12] = mk(16'h8000, 3'd0, ALUOP_ADD,               32'hFFFF_8001, 1'b0);
      vecs[13] = mk(16'h0024, 3'd6, ALUOP_SHIFT_LEFT,        32'hFFF8_0010, 1'b0);
      vecs[14] = mk(16'h0000, 3'd2, ALUOP_AND,               32'h0000_0000, 1'b1);
      vecs[15] = mk(16'h0003, 3'd0, ALUOP_ADD,               32'h0000_0003, 1'b0);
      vecs[16] = mk(16'h0003, 3'd1, ALUOP_SUB,               32'h0000_0000, 1'b1);

      // Reset with btnc held: state clears, then exactly one execute after release.
      rst = 1'b1; btnc = 1'b1; sw = 16'h0002; op_sel = 3'd0;
      repeat (4) @(posedge clk);
      #1;
      check("rst acc", acc, 32'd0);
      check("rst busy", 32'(busy), 32'd0);
      check("rst op_count", 32'(op_count), 32'd0);
      check("rst zero", 32'(zero_flag), 32'd0);
      check("rst alu_op2", aif.alu_op2, 32'd0);
      check("rst alu_op", 32'(aif.alu_op), 32'(ALUOP_ADD));
      rst = 1'b0;
      bc = 0;
      repeat (12) begin
         @(posedge clk);
         #1;
         if (busy) bc++;
      end
      check("held-btnc busy cycles", 32'(bc), 32'd1);
      check("held-btnc acc", acc, 32'd2);
      check("held-btnc op_count", 32'(op_count), 32'd1);
      btnc = 1'b0;
      repeat (4) @(posedge clk);
      #1;

      // Reset during EXEC discards the writeback.
      sw = 16'h0009; op_sel = 3'd0; btnc = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("midexec busy", 32'(busy), 32'd1);
      rst = 1'b1; btnc = 1'b0;
      @(posedge clk);
      #1;
      check("midexec acc", acc, 32'd0);
      check("midexec busy after rst", 32'(busy), 32'd0);
      check("midexec op_count", 32'(op_count), 32'd0);
      do_reset();

      for (int i = 0; i < 17; i++) begin
         exec_op($sformatf("vec%0d", i), vecs[i]);
      end

      // Clear and execute in the same cycle: clear wins.
      exec_op("add7", mk(16'h0007, 3'd0, ALUOP_ADD, 32'd7, 1'b0));
      sw = 16'h0001; op_sel = 3'd0;
      press(1'b1, 1'b1, 1'b0, 8, bc);
      model_acc = '0;
      check("clr+exe busy cycles", 32'(bc), 32'd0);
      check("clr+exe acc", acc, 32'd0);
      check("clr+exe zero", 32'(zero_flag), 32'd1);
      check("clr+exe op_count", 32'(op_count), 32'(model_cnt));

      // btnc held 100 cycles executes once.
      sw = 16'h0001; op_sel = 3'd0;
      press(1'b1, 1'b0, 1'b0, 100, bc);
      model_acc = model_acc + 32'd1;
      model_cnt = model_cnt + 8'd1;
      check("hold busy cycles", 32'(bc), 32'd1);
      check("hold acc", acc, model_acc);
      check("hold op_count", 32'(op_count), 32'(model_cnt));

      // Clear pulse landing in EXEC is discarded.
      sw = 16'h0005; op_sel = 3'd0; btnc = 1'b1;
      @(posedge clk);
      #1;
      btnl = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("clr-in-exec busy", 32'(busy), 32'd1);
      @(posedge clk);
      #1;
      model_acc = model_acc + 32'd5;
      model_cnt = model_cnt + 8'd1;
      check("clr-in-exec acc", acc, model_acc);
      check("clr-in-exec zero", 32'(zero_flag), 32'd0);
      repeat (4) @(posedge clk);
      #1;
      check("clr-in-exec acc later", acc, model_acc);
      check("clr-in-exec op_count", 32'(op_count), 32'(model_cnt));
      btnc = 1'b0; btnl = 1'b0;
      repeat (4) @(posedge clk);
      #1;

`ifdef CALC_UNDO_EN
      do_reset();
      check("undo rst depth", 32'(undo_depth), 32'd0);
      exec_op("u add1", mk(16'h0001, 3'd0, ALUOP_ADD, 32'd1, 1'b0));
      exec_op("u add2", mk(16'h0002, 3'd0, ALUOP_ADD, 32'd3, 1'b0));
      check("u depth2", 32'(undo_depth), 32'd2);
      press(1'b0, 1'b1, 1'b0, 6, bc);
      check("u clr acc", acc, 32'd0);
      check("u clr depth", 32'(undo_depth), 32'd3);
      press(1'b0, 1'b0, 1'b1, 6, bc);
      check("u undo1 acc", acc, 32'd3);
      press(1'b0, 1'b0, 1'b1, 6, bc);
      check("u undo2 acc", acc, 32'd1);
      check("u undo2 depth", 32'(undo_depth), 32'd1);
      sw = 16'h0005; op_sel = 3'd0;
      press(1'b1, 1'b0, 1'b1, 8, bc);
      check("u undo>exe busy", 32'(bc), 32'd0);
      check("u undo>exe acc", acc, 32'd0);
      check("u undo>exe depth", 32'(undo_depth), 32'd0);
      check("u undo>exe op_count", 32'(op_count), 32'(model_cnt));
      model_acc = '0;
      for (int i = 1; i <= 6; i++) begin
         exec_op($sformatf("u push%0d", i),
                 mk(16'(10 * i), 3'd0, ALUOP_ADD, model_acc + 32'(10 * i), 1'b0));
      end
      check("u full depth", 32'(undo_depth), 32'd4);
      begin
         logic [31:0] exp_pop [5];
         exp_pop[0] = 32'd150; exp_pop[1] = 32'd100; exp_pop[2] = 32'd60;
         exp_pop[3] = 32'd30;  exp_pop[4] = 32'd30;
         for (int i = 0; i < 5; i++) begin
            press(1'b0, 1'b0, 1'b1, 6, bc);
            check($sformatf("u pop%0d acc", i), acc, exp_pop[i]);
         end
      end
      check("u empty depth", 32'(undo_depth), 32'd0);
      exec_op("u pre-rst", mk(16'h0001, 3'd0, ALUOP_ADD, 32'd31, 1'b0));
      check("u pre-rst depth", 32'(undo_depth), 32'd1);
      do_reset();
      check("u post-rst depth", 32'(undo_depth), 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
